operand_scoreboard: RTL and testbench
=====================================

# operand_scoreboard

Parametrised operand-resolution and hazard block for the decode stage of the MIPS pipeline. It keeps its own shift-register record of destination registers in flight through NSTAGE downstream stages, and drives forwarded operands onto NREAD read ports. It raises a single decode stall for data that is not yet available (e.g. loads) and for a busy multi-cycle multiply/divide unit (MDU). This replaces ad-hoc per-port compare logic and allows wider issue and deeper pipelines.

## Interface
- NREAD, 2, number of register read ports resolved per cycle
- NSTAGE, 3, in-flight stages tracked (index 0 = execute, 1 = memory, 2 = writeback)
- LOAD_RDY, 1, first stage index at which load data is valid
- MDU_LAT, 32, MDU busy cycles after an accepted start (1..255)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_ra[NREAD]  in  5 each  source register numbers
- id_rd[NREAD]  in  32 each  register-file read data
- id_wr_en, id_wreg  in  1 / 5  instruction writes GPR id_wreg
- id_is_load  in  1  result available only at stage LOAD_RDY
- id_hilo_use  in  1  instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- id_mdu_start  in  1  instruction starts the MDU (mult/div)
- stg_val[NSTAGE]  in  32 each  result value currently held in each stage
- pipe_hold  in  1  downstream freeze; pipeline registers do not advance
- opnd[NREAD]  out  32 each  resolved operands
- stall  out  1  decode must not issue this cycle
- id_fire  out  1  id_valid & ~stall & ~pipe_hold
- mdu_busy  out  1  MDU countdown non-zero

## Operation
- Entry per stage: {vld, reg[4:0], rdy_at}, where rdy_at = LOAD_RDY for loads and 0 otherwise.
- Per port p: when id_ra[p] == 0, opnd = 0. Otherwise, the youngest (lowest-index) valid entry with reg == id_ra[p] wins, and opnd = stg_val[s].
  - If the winning entry has s < rdy_at, the data is not ready: raise a data stall.
  - If no entry matches, opnd = id_rd[p].
- Entries with reg 0 are never created.
- MDU stall when mdu_busy and (id_hilo_use or id_mdu_start).
- stall = id_valid & (data stall on any port | MDU stall). stall is purely combinational and has no dependency on pipe_hold.
- Register update on clk:
  - pipe_hold = 1: all entries freeze.
  - Else: entries shift s → s+1 and the oldest is discarded. Stage 0 receives:
    - {1, id_wreg, rdy} on id_fire with id_wr_en and id_wreg != 0;
    - otherwise a bubble (vld = 0), including on stall.
- MDU counter:
  - Loaded with MDU_LAT on id_fire & id_mdu_start.
  - Otherwise decrements by 1 while non-zero, every cycle regardless of pipe_hold.
  - mdu_busy = (cnt != 0).

## Timing
- Reset (asynchronous, resetn = 0): all vld = 0, cnt = 0. Outputs then give stall = 0 and mdu_busy = 0. Each opnd passes id_rd, or 0 for register 0.
- Forwarding and stall are zero-latency combinational from the inputs and current entries.
- Load-use with LOAD_RDY = 1:
  - Consumer directly behind a load stalls exactly 1 cycle, then takes stg_val[1].
  - Consumer two behind gets no stall.
- Multiple matches: the youngest entry always wins, even when an older entry is ready and the younger one is not; this produces a stall.
- Simultaneous id_fire and a pending decrement: the load wins (cnt = MDU_LAT).
- An MDU start issued at cycle t asserts mdu_busy from t+1 through t+MDU_LAT. mfhi stalls for those cycles.
- While pipe_hold = 1: opnd and stall continue to evaluate against the frozen entries, and id_fire = 0.
- resetn deasserted mid-operation: entries and cnt clear immediately; no stale forwarding is allowed afterwards.

## Structure
- The entry struct type sb_entry_t and the LOAD_RDY/MDU_LAT defaults go in the shared pipeline header alongside the D/E stage types.
- One sub-module, mdu_busy_counter, holds the load/decrement counter and generates mdu_busy; width is $clog2(MDU_LAT+1).
- Per-port resolution is a generate loop over NREAD with a priority scan over NSTAGE.

## Test plan
- Reset, id_ra = {3, 0}, id_rd = {0x11, 0x22}: opnd = {0x11, 0}, stall = 0, mdu_busy = 0.
- addu $5 fires; next cycle id_ra[0] = 5, stg_val[0] = 0xABCD: opnd[0] = 0xABCD, stall = 0. One cycle later opnd[0] = stg_val[1].
- lw $7 fires; next cycle id_ra[1] = 7: stall = 1 for exactly 1 cycle. Then opnd[1] = stg_val[1] = 0x1234.
- $4 written at stages 2 and 0 with distinct values: opnd gets the stage-0 value.
- div fires with MDU_LAT = 4, then mflo presented: stall = 1 for 4 cycles, mdu_busy falls on cycle 5, and id_fire follows.
- pipe_hold = 1 for 3 cycles after addu $9: the entry stays at stage 0 and cnt still decrements. Pull resetn low mid-hold: all entries clear and stall = 0.

Source files
------------

// File: rtl/operand_scoreboard_pkg.sv
// Purpose : shared decode/execute pipeline types for the operand scoreboard.
// Latency : n/a (types and defaults only).
// Backpr. : n/a.
package operand_scoreboard_pkg;

    // Default stage index at which load data becomes forwardable.
    localparam int SB_LOAD_RDY_DEF = 1;
    // Default MDU busy cycles after an accepted mult/div start.
    localparam int SB_MDU_LAT_DEF  = 32;
    // Width of the ready-at stage index carried in each entry.
    localparam int SB_RDY_W        = 4;

    // Decode-stage control bundle for the instruction held in D.
    typedef struct packed {
        logic       wr_en;
        logic [4:0] wreg;
        logic       is_load;
        logic       hilo_use;
        logic       mdu_start;
    } id_ctl_t;

    // One in-flight destination record per downstream stage (E, M, W...).
    typedef struct packed {
        logic                vld;
        logic [4:0]          wreg;
        logic [SB_RDY_W-1:0] rdy_at;
    } sb_entry_t;

endpackage

// File: rtl/operand_scoreboard_if.sv
// Purpose : decode <-> scoreboard signal bundle; master = decode, slave = scoreboard.
// Latency : n/a (wiring only).
// Backpr. : stall/id_fire flow back to decode; pipe_hold freezes the tracked entries.
interface operand_scoreboard_if #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 3
);
    logic        id_valid;
    logic [4:0]  id_ra   [NREAD];
    logic [31:0] id_rd   [NREAD];
    logic        id_wr_en;
    logic [4:0]  id_wreg;
    logic        id_is_load;
    logic        id_hilo_use;
    logic        id_mdu_start;
    logic [31:0] stg_val [NSTAGE];
    logic        pipe_hold;
    logic [31:0] opnd    [NREAD];
    logic        stall;
    logic        id_fire;
    logic        mdu_busy;

    modport master (
        output id_valid, id_ra, id_rd, id_wr_en, id_wreg, id_is_load,
               id_hilo_use, id_mdu_start, stg_val, pipe_hold,
        input  opnd, stall, id_fire, mdu_busy
    );

    modport slave (
        input  id_valid, id_ra, id_rd, id_wr_en, id_wreg, id_is_load,
               id_hilo_use, id_mdu_start, stg_val, pipe_hold,
        output opnd, stall, id_fire, mdu_busy
    );
endinterface

// File: rtl/operand_scoreboard_mdu_busy_counter.sv
// Purpose : MDU busy countdown; load on accepted start, else decrement to zero.
// Latency : busy asserts the cycle after load and stays up for MDU_LAT cycles.
// Backpr. : none; counts every cycle regardless of pipeline hold.
// Ports   : clk, resetn, load (accepted mult/div start), busy (count != 0).
module mdu_busy_counter #(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    output logic busy
);
    localparam int CW = $clog2(MDU_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A fresh start overrides a pending decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(MDU_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
endmodule

// File: rtl/operand_scoreboard.sv
// Purpose : decode-stage operand forwarding and hazard stall over NSTAGE tracked stages.
// Latency : opnd/stall/id_fire combinational; entries update on the clock edge.
// Backpr. : pipe_hold freezes entries and blocks id_fire; stall ignores pipe_hold.
// Ports   : clk, resetn (async, active-low), sb (slave modport of operand_scoreboard_if).
module operand_scoreboard
    import operand_scoreboard_pkg::*;
#(
    parameter int NREAD    = 2,
    parameter int NSTAGE   = 3,
    parameter int LOAD_RDY = SB_LOAD_RDY_DEF,
    parameter int MDU_LAT  = SB_MDU_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    operand_scoreboard_if.slave  sb
);
    sb_entry_t        ent_q [NSTAGE];
    sb_entry_t        ent_d [NSTAGE];
    sb_entry_t        new_ent;
    id_ctl_t          id_ctl;
    logic [NREAD-1:0] data_stall;
    logic             mdu_busy;
    logic             stall;
    logic             fire;

    assign id_ctl = '{
        wr_en:     sb.id_wr_en,
        wreg:      sb.id_wreg,
        is_load:   sb.id_is_load,
        hilo_use:  sb.id_hilo_use,
        mdu_start: sb.id_mdu_start
    };

    // Per-port resolution: scan oldest to youngest so the youngest match overrides.
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [31:0] opnd_p;
        logic        nrdy_p;

        always_comb begin
            opnd_p = sb.id_rd[p];
            nrdy_p = 1'b0;
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (ent_q[s].vld && (ent_q[s].wreg == sb.id_ra[p])) begin
                    opnd_p = sb.stg_val[s];
                    nrdy_p = (s < int'(ent_q[s].rdy_at));
                end
            end
            if (sb.id_ra[p] == 5'd0) begin
                opnd_p = '0;
                nrdy_p = 1'b0;
            end
        end

        assign sb.opnd[p]    = opnd_p;
        assign data_stall[p] = nrdy_p;
    end

    assign stall = sb.id_valid &
                   ((|data_stall) | (mdu_busy & (id_ctl.hilo_use | id_ctl.mdu_start)));
    assign fire  = sb.id_valid & ~stall & ~sb.pipe_hold;

    // Stage-0 entry: a real writer only when the instruction actually issues.
    always_comb begin
        new_ent = '0;
        if (fire && id_ctl.wr_en && (id_ctl.wreg != 5'd0)) begin
            new_ent.vld    = 1'b1;
            new_ent.wreg   = id_ctl.wreg;
            new_ent.rdy_at = id_ctl.is_load ? SB_RDY_W'(LOAD_RDY) : '0;
        end
    end

    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            ent_d[s] = ent_q[s];
        end
        if (!sb.pipe_hold) begin
            ent_d[0] = new_ent;
            for (int s = 1; s < NSTAGE; s++) begin
                ent_d[s] = ent_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NSTAGE; s++) begin
                ent_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTAGE; s++) begin
                ent_q[s] <= ent_d[s];
            end
        end
    end

    mdu_busy_counter #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_busy_counter (
        .clk    (clk),
        .resetn (resetn),
        .load   (fire & id_ctl.mdu_start),
        .busy   (mdu_busy)
    );

    assign sb.stall    = stall;
    assign sb.id_fire  = fire;
    assign sb.mdu_busy = mdu_busy;
endmodule

// File: tb/tb_operand_scoreboard.sv
// Purpose : randomized + directed scoreboard bench for operand_scoreboard.
// Latency : expected outputs predicted per cycle, checked by an independent monitor.
// Backpr. : exercises stall, pipe_hold and MDU busy paths.
module tb_operand_scoreboard;
    localparam int NREAD    = 2;
    localparam int NSTAGE   = 3;
    localparam int LOAD_RDY = 1;
    localparam int MDU_LAT  = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    operand_scoreboard_if #(.NREAD(NREAD), .NSTAGE(NSTAGE)) sb_if();

    operand_scoreboard #(
        .NREAD    (NREAD),
        .NSTAGE   (NSTAGE),
        .LOAD_RDY (LOAD_RDY),
        .MDU_LAT  (MDU_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb_if)
    );

    // History of issue slots, newest first: element i is what now sits in stage i.
    typedef struct {
        bit       wr;
        bit [4:0] r;
        bit       ld;
    } slot_t;

    typedef struct {
        logic [NREAD-1:0][31:0] opnd;
        logic                   stall;
        logic                   fire;
        logic                   busy;
    } exp_t;

    slot_t hist[$];
    exp_t  exp_q[$];
    int    cyc;
    int    start_cyc;
    bit    have_start;
    int    errors;
    int    checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, req);
        end
    endtask

    task automatic clear_model();
        slot_t b;
        b = '{wr: 1'b0, r: 5'd0, ld: 1'b0};
        hist.delete();
        for (int i = 0; i < NSTAGE; i++) hist.push_back(b);
        have_start = 1'b0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        bit   ds;
        int   age;
        ds  = 1'b0;
        age = cyc - start_cyc;
        e.busy = have_start && (age >= 1) && (age <= MDU_LAT);
        for (int p = 0; p < NREAD; p++) begin
            e.opnd[p] = sb_if.id_rd[p];
            if (sb_if.id_ra[p] == 5'd0) begin
                e.opnd[p] = 32'd0;
            end else begin
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i].wr && hist[i].r == sb_if.id_ra[p]) begin
                        e.opnd[p] = sb_if.stg_val[i];
                        if (hist[i].ld && i < LOAD_RDY) ds = 1'b1;
                        break;
                    end
                end
            end
        end
        e.stall = sb_if.id_valid &&
                  (ds || (e.busy && (sb_if.id_hilo_use || sb_if.id_mdu_start)));
        e.fire  = sb_if.id_valid && !e.stall && !sb_if.pipe_hold;
        return e;
    endfunction

    // Inputs are set by the caller shortly after a rising edge; prediction happens
    // at the falling edge and the model advances just after the next rising edge.
    task automatic step();
        exp_t  e;
        slot_t sl;
        @(negedge clk);
        if (!resetn) clear_model();
        e = predict();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (resetn) begin
            if (e.fire && sb_if.id_mdu_start) begin
                have_start = 1'b1;
                start_cyc  = cyc;
            end
            if (!sb_if.pipe_hold) begin
                sl.wr = e.fire && sb_if.id_wr_en && (sb_if.id_wreg != 5'd0);
                sl.r  = sb_if.id_wreg;
                sl.ld = sb_if.id_is_load;
                hist.push_front(sl);
                void'(hist.pop_back());
            end
        end
        cyc++;
    endtask

    task automatic rand_data();
        for (int p = 0; p < NREAD; p++) sb_if.id_rd[p] = $urandom;
        for (int s = 0; s < NSTAGE; s++) sb_if.stg_val[s] = $urandom;
    endtask

    task automatic idle();
        sb_if.id_valid     = 1'b0;
        sb_if.id_wr_en     = 1'b0;
        sb_if.id_wreg      = 5'd0;
        sb_if.id_is_load   = 1'b0;
        sb_if.id_hilo_use  = 1'b0;
        sb_if.id_mdu_start = 1'b0;
        sb_if.pipe_hold    = 1'b0;
        sb_if.id_ra[0]     = 5'd0;
        sb_if.id_ra[1]     = 5'd0;
        rand_data();
    endtask

    task automatic issue(input bit wr, input logic [4:0] wreg, input bit ld);
        sb_if.id_valid   = 1'b1;
        sb_if.id_wr_en   = wr;
        sb_if.id_wreg    = wreg;
        sb_if.id_is_load = ld;
    endtask

    // Monitor: compares DUT outputs against the predicted queue each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NREAD; p++) chk($sformatf("opnd%0d", p), sb_if.opnd[p], e.opnd[p]);
                chk("stall",    {31'd0, sb_if.stall},    {31'd0, e.stall});
                chk("id_fire",  {31'd0, sb_if.id_fire},  {31'd0, e.fire});
                chk("mdu_busy", {31'd0, sb_if.mdu_busy}, {31'd0, e.busy});
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        start_cyc = 0;
        resetn = 1'b0;
        idle();
        clear_model();

        // Reset values: register 0 reads zero, others pass the register file.
        sb_if.id_ra[0] = 5'd3;
        sb_if.id_ra[1] = 5'd0;
        sb_if.id_rd[0] = 32'h11;
        sb_if.id_rd[1] = 32'h22;
        step();
        step();
        resetn = 1'b1;
        idle();
        step();

        // ALU result forwarded from E, then from M.
        idle(); issue(1'b1, 5'd5, 1'b0); step();
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd5; sb_if.stg_val[0] = 32'hABCD; step();
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd5; step();

        // Load-use: one stall, then M-stage value.
        idle(); issue(1'b1, 5'd7, 1'b1); step();
        repeat (2) begin
            idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[1] = 5'd7; sb_if.stg_val[1] = 32'h1234; step();
        end

        // Two writers of $4: youngest wins.
        idle(); issue(1'b1, 5'd4, 1'b0); step();
        idle(); step();
        idle(); issue(1'b1, 5'd4, 1'b0); step();
        idle(); sb_if.id_valid = 1'b1; sb_if.id_ra[0] = 5'd4; sb_if.id_ra[1] = 5'd4;
        sb_if.stg_val[0] = 32'hAAAA_0000; sb_if.stg_val[2] = 32'h5555_0000; step();

        // Younger unready load shadows an older ready writer.
        idle(); issue(1'b1, 5'd6, 1'b0); step();
        idle(); issue(1'b1, 5'd6, 1'b1); step();
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd6; step();

        // div then mflo: stalls while the MDU is busy.
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_mdu_start = 1'b1; sb_if.id_hilo_use = 1'b1; step();
        repeat (6) begin
            idle(); issue(1'b1, 5'd3, 1'b0); sb_if.id_hilo_use = 1'b1; step();
        end

        // Hold freezes entries while the MDU count keeps running; reset mid-hold.
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_mdu_start = 1'b1; step();
        idle(); issue(1'b1, 5'd9, 1'b0); step();
        repeat (3) begin
            idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd9; sb_if.id_hilo_use = 1'b1;
            sb_if.pipe_hold = 1'b1; step();
        end
        resetn = 1'b0;
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd9; sb_if.pipe_hold = 1'b1; step();
        resetn = 1'b1;
        idle(); issue(1'b0, 5'd0, 1'b0); sb_if.id_ra[0] = 5'd9; sb_if.id_hilo_use = 1'b1; step();

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            resetn             = ($urandom_range(0, 199) != 0);
            sb_if.id_valid     = ($urandom_range(0, 3) != 0);
            sb_if.id_wr_en     = ($urandom_range(0, 3) != 0);
            sb_if.id_wreg      = 5'($urandom_range(0, 7));
            sb_if.id_is_load   = ($urandom_range(0, 9) < 3);
            sb_if.id_hilo_use  = ($urandom_range(0, 19) < 3);
            sb_if.id_mdu_start = ($urandom_range(0, 9) == 0);
            sb_if.pipe_hold    = ($urandom_range(0, 4) == 0);
            for (int p = 0; p < NREAD; p++) sb_if.id_ra[p] = 5'($urandom_range(0, 7));
            rand_data();
            step();
        end

        @(negedge clk);
        #4;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
